// File: rtl/obstacle_pkg.sv
// Shared types and constants for the obstacle spawner: lane masks, FSM states and the row record.
package obstacle_pkg;

  localparam int NUM_LANES    = 3;
  // Row ids are held at this width internally; ROW_ID_W must be 1..ROW_ID_MAX_W.
  localparam int ROW_ID_MAX_W = 16;

  localparam logic [NUM_LANES-1:0] CENTRE_OPEN_MASK = 3'b101;
  localparam logic [NUM_LANES-1:0] ALL_LANES_MASK   = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    SAMPLE,
    EMIT
  } spawner_state_t;

  typedef struct packed {
    logic [NUM_LANES-1:0]    lanes;
    logic                    kind;
    logic [ROW_ID_MAX_W-1:0] row_id;
  } obstacle_row_t;

  // A fully blocked row is unplayable, so the centre lane is reopened.
  function automatic logic [NUM_LANES-1:0] safe_mask(input logic [NUM_LANES-1:0] cand);
    return (cand == ALL_LANES_MASK) ? CENTRE_OPEN_MASK : cand;
  endfunction

endpackage

// File: rtl/obstacle_spawner_if.sv
// Valid/ready obstacle-row channel from the spawner (master) to the track renderer (slave).
interface obstacle_spawner_if #(
  parameter int ROW_ID_W = 8
);
  import obstacle_pkg::*;

  logic                 obs_valid;
  logic                 obs_ready;
  logic [NUM_LANES-1:0] obs_lanes;
  logic                 obs_kind;
  logic [ROW_ID_W-1:0]  obs_row_id;

  modport master (
    output obs_valid,
    output obs_lanes,
    output obs_kind,
    output obs_row_id,
    input  obs_ready
  );

  modport slave (
    input  obs_valid,
    input  obs_lanes,
    input  obs_kind,
    input  obs_row_id,
    output obs_ready
  );

endinterface

// File: rtl/obstacle_spawner.sv
// Turns spawn ticks plus an LFSR nibble into obstacle rows on a valid/ready channel.
// Optional drop-statistics counter enabled by defining OBSTACLE_STATS_EN.
module obstacle_spawner
  import obstacle_pkg::*;
#(
  parameter int MIN_GAP  = 2,
  parameter int ROW_ID_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                run,
  input  logic                spawn_tick,
  input  logic [3:0]          rand_in,
`ifdef OBSTACLE_STATS_EN
  output logic [7:0]          drop_cnt,
`endif
  obstacle_spawner_if.master  obs
);

  localparam logic [3:0]              GAP_LOAD = 4'(MIN_GAP);
  localparam logic [ROW_ID_MAX_W-1:0] ID_ONE   = ROW_ID_MAX_W'(1);
  localparam logic [ROW_ID_MAX_W-1:0] ID_WRAP  = ROW_ID_MAX_W'((32'd1 << ROW_ID_W) - 32'd1);

  spawner_state_t          state_reg;
  logic                    valid_reg;
  logic [3:0]              gap_cnt_reg;
  obstacle_row_t           row_reg;
  logic [NUM_LANES-1:0]    cand_mask;
  logic [ROW_ID_MAX_W-1:0] id_next;

  assign cand_mask = rand_in[NUM_LANES-1:0];
  // Wrap at the configured width; the upper internal bits stay zero.
  assign id_next   = (row_reg.row_id == ID_WRAP) ? '0 : row_reg.row_id + ID_ONE;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      valid_reg   <= 1'b0;
      gap_cnt_reg <= '0;
      row_reg     <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (run && spawn_tick) begin
            if (gap_cnt_reg == 4'd0) begin
              state_reg <= SAMPLE;
            end else begin
              gap_cnt_reg <= gap_cnt_reg - 4'd1;
            end
          end
        end
        SAMPLE: begin
          // An empty candidate row spawns nothing and costs no gap.
          if (cand_mask == '0) begin
            state_reg <= IDLE;
          end else begin
            row_reg.lanes <= safe_mask(cand_mask);
            row_reg.kind  <= rand_in[3];
            gap_cnt_reg   <= GAP_LOAD;
            valid_reg     <= 1'b1;
            state_reg     <= EMIT;
          end
        end
        EMIT: begin
          if (obs.obs_ready) begin
            valid_reg      <= 1'b0;
            row_reg.row_id <= id_next;
            state_reg      <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign obs.obs_valid  = valid_reg;
  assign obs.obs_lanes  = row_reg.lanes;
  assign obs.obs_kind   = row_reg.kind;
  assign obs.obs_row_id = row_reg.row_id[ROW_ID_W-1:0];

`ifdef OBSTACLE_STATS_EN
  logic [7:0] drop_cnt_reg;

  // Ticks arriving while a row is in flight are lost; count them, saturating.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt_reg <= '0;
    end else if (run && spawn_tick && (state_reg != IDLE) && (drop_cnt_reg != 8'hFF)) begin
      drop_cnt_reg <= drop_cnt_reg + 8'd1;
    end
  end

  assign drop_cnt = drop_cnt_reg;
`endif

endmodule

// File: tb/tb_obstacle_spawner.sv
// Directed self-checking bench for obstacle_spawner (drop counter checks under OBSTACLE_STATS_EN).
module tb_obstacle_spawner;

  logic       clk = 1'b0;
  logic       rst;
  logic       run;
  logic       spawn_tick;
  logic [3:0] rand_in;
`ifdef OBSTACLE_STATS_EN
  logic [7:0] drop_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  obstacle_spawner_if #(.ROW_ID_W(8)) bus ();

  obstacle_spawner #(
    .MIN_GAP (2),
    .ROW_ID_W(8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .spawn_tick(spawn_tick),
    .rand_in   (rand_in),
`ifdef OBSTACLE_STATS_EN
    .drop_cnt  (drop_cnt),
`endif
    .obs       (bus)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Tick sampled at the next edge; r_next is the nibble presented in the following (SAMPLE) cycle.
  task automatic tick_step(input logic [3:0] r_next);
    spawn_tick = 1'b1;
    step();
    spawn_tick = 1'b0;
    rand_in    = r_next;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_cmp++;
    assert (observed === expected)
    else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    logic seen;
    rst = 1'b1; run = 1'b1; spawn_tick = 1'b0; rand_in = 4'h0; bus.obs_ready = 1'b0;
    step(); step();
    check("rst_valid", 32'(bus.obs_valid), 32'd0);
    check("rst_lanes", 32'(bus.obs_lanes), 32'd0);
    check("rst_kind", 32'(bus.obs_kind), 32'd0);
    check("rst_row_id", 32'(bus.obs_row_id), 32'd0);
`ifdef OBSTACLE_STATS_EN
    check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
`endif
    rst = 1'b0;

    // Basic row: valid exactly two cycles after the tick
    tick_step(4'b1011);
    check("a_sample_no_valid", 32'(bus.obs_valid), 32'd0);
    step();
    check("a_valid", 32'(bus.obs_valid), 32'd1);
    check("a_lanes", 32'(bus.obs_lanes), 32'b011);
    check("a_kind", 32'(bus.obs_kind), 32'd1);
    check("a_row_id", 32'(bus.obs_row_id), 32'd0);
    bus.obs_ready = 1'b1;
    step();
    check("a_done_valid", 32'(bus.obs_valid), 32'd0);
    check("a_row_id_inc", 32'(bus.obs_row_id), 32'd1);

    // Gap spacing: ticks every 4 cycles, rows on ticks 1, 4 and 7
    rst = 1'b1; step(); rst = 1'b0;
    for (int t = 1; t <= 7; t++) begin
      seen = 1'b0;
      tick_step(4'b0001);
      for (int c = 0; c < 3; c++) begin
        if (bus.obs_valid) seen = 1'b1;
        step();
      end
      check($sformatf("gap_tick%0d", t), 32'(seen), 32'((t == 1) || (t == 4) || (t == 7)));
    end
    check("gap_row_id", 32'(bus.obs_row_id), 32'd3);

    // All-lanes candidate reopens centre; then backpressure with ticks dropped
    rst = 1'b1; step(); rst = 1'b0; bus.obs_ready = 1'b0;
    tick_step(4'b0111);
    step();
    check("b_valid", 32'(bus.obs_valid), 32'd1);
    check("b_lanes", 32'(bus.obs_lanes), 32'b101);
    check("b_kind", 32'(bus.obs_kind), 32'd0);
    for (int c = 0; c < 10; c++) begin
      spawn_tick = (c == 1) || (c == 4) || (c == 7);
      step();
      check($sformatf("hold_c%0d", c),
            32'({bus.obs_valid, bus.obs_lanes, bus.obs_kind, bus.obs_row_id}),
            32'({1'b1, 3'b101, 1'b0, 8'd0}));
    end
    spawn_tick = 1'b0;
`ifdef OBSTACLE_STATS_EN
    check("hold_drop_cnt", 32'(drop_cnt), 32'd3);
`endif
    bus.obs_ready = 1'b1;
    step();
    check("hold_xfer_valid", 32'(bus.obs_valid), 32'd0);
    check("hold_xfer_row_id", 32'(bus.obs_row_id), 32'd1);

    // Empty candidate: nothing emitted, next tick samples at once; run drop in SAMPLE finishes row
    rst = 1'b1; step(); rst = 1'b0;
    tick_step(4'b1000);
    check("d_empty_sample", 32'(bus.obs_valid), 32'd0);
    step();
    check("d_empty_idle", 32'(bus.obs_valid), 32'd0);
    tick_step(4'b0010);
    run = 1'b0;
    step();
    check("d_valid", 32'(bus.obs_valid), 32'd1);
    check("d_lanes", 32'(bus.obs_lanes), 32'b010);
    check("d_kind", 32'(bus.obs_kind), 32'd0);
    step();
    check("d_done_valid", 32'(bus.obs_valid), 32'd0);
    check("d_row_id", 32'(bus.obs_row_id), 32'd1);
    run = 1'b1;

    // Reset mid-EMIT abandons the row and clears counters
    bus.obs_ready = 1'b0;
    tick_step(4'b0000);
    tick_step(4'b0000);
    tick_step(4'b0100);
    step();
    check("e_valid", 32'(bus.obs_valid), 32'd1);
    check("e_lanes", 32'(bus.obs_lanes), 32'b100);
    spawn_tick = 1'b1;
    step();
    spawn_tick = 1'b0;
`ifdef OBSTACLE_STATS_EN
    check("e_drop_cnt", 32'(drop_cnt), 32'd1);
`endif
    rst = 1'b1;
    step();
    check("e_rst_valid", 32'(bus.obs_valid), 32'd0);
    check("e_rst_row_id", 32'(bus.obs_row_id), 32'd0);
    check("e_rst_lanes", 32'(bus.obs_lanes), 32'd0);
`ifdef OBSTACLE_STATS_EN
    check("e_rst_drop_cnt", 32'(drop_cnt), 32'd0);
`endif
    rst = 1'b0;
    bus.obs_ready = 1'b1;
    step();
    check("e_after_rst_valid", 32'(bus.obs_valid), 32'd0);

    // Ticks ignored while run is low
    run = 1'b0;
    tick_step(4'b0001);
    step();
    check("run_low_valid", 32'(bus.obs_valid), 32'd0);
    run = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/obstacle_spawner.md
OBSTACLE_SPAWNER -- requirements
Module: obstacle_spawner

Interface
REQ-001 SHALL have parameter MIN_GAP, default 2, meaning the number of spawn ticks skipped after each emitted row (range 0-15).
REQ-002 SHALL have parameter ROW_ID_W, default 8, meaning the width of the emitted row index.
REQ-003 SHALL have port clk  input  1  meaning the single system clock; all logic is on its rising edge.
REQ-004 SHALL have port rst  input  1  meaning synchronous, active-high reset.
REQ-005 SHALL have port run  input  1  meaning the spawner is enabled; when low, spawn ticks are ignored.
REQ-006 SHALL have port spawn_tick  input  1  meaning a one-cycle pulse per track-segment advance.
REQ-007 SHALL have port rand_in  input  4  meaning the random nibble driven by the upstream 4-bit LFSR output.
REQ-008 SHALL have port obs_valid  output  1  meaning an obstacle row is presented.
REQ-009 SHALL have port obs_ready  input  1  meaning the downstream consumer accepts the row.
REQ-010 SHALL have port obs_lanes  output  3  meaning the blocked-lane mask, bit0 = left, bit1 = centre, bit2 = right.
REQ-011 SHALL have port obs_kind  output  1  meaning the obstacle type: 0 = low barrier, 1 = train.
REQ-012 SHALL have port obs_row_id  output  ROW_ID_W  meaning the sequence number of the emitted row.
REQ-013 SHALL have port drop_cnt  output  8  meaning the number of ticks lost to backpressure (present only under OBSTACLE_STATS_EN).

Function
REQ-014 SHALL implement a state machine with states IDLE, SAMPLE and EMIT.
REQ-015 SHALL, in IDLE with run=1, spawn_tick=1 and gap_cnt=0, move to SAMPLE.
REQ-016 SHALL, in IDLE with run=1, spawn_tick=1 and gap_cnt>0, decrement gap_cnt, stay in IDLE and sample nothing.
REQ-017 SHALL, in SAMPLE, capture rand_in (the value one cycle after the tick, after the LFSR has stepped) using the following mapping.
REQ-018 SHALL map candidate lane mask = rand_in[2:0] and obs_kind = rand_in[3].
REQ-019 SHALL replace a candidate mask of 3'b111 with 3'b101, so the centre lane stays open and at least one lane is always free.
REQ-020 SHALL, when the candidate mask is 3'b000, emit nothing, leave gap_cnt at 0 and return to IDLE.
REQ-021 SHALL, when the candidate mask is non-zero, register the row, load gap_cnt with MIN_GAP and go to EMIT.
REQ-022 SHALL assert obs_valid in EMIT only, giving tick-to-valid latency of exactly 2 cycles.
REQ-023 SHALL hold obs_lanes, obs_kind and obs_row_id stable while obs_valid=1 and obs_ready=0.
REQ-024 SHALL, on obs_valid && obs_ready, complete the transfer, increment obs_row_id with wrap from all-ones to 0, and return to IDLE in the next cycle.
REQ-025 SHALL drop any spawn_tick seen in SAMPLE or EMIT, including one coincident with the handshake cycle, without changing gap_cnt.
REQ-026 SHALL, when run deasserts in SAMPLE or EMIT, finish the current row normally.

Reset
REQ-027 SHALL, on rst=1 at a clock edge, force state=IDLE, obs_valid=0, obs_lanes=0, obs_kind=0, obs_row_id=0, gap_cnt=0 and drop_cnt=0.
REQ-028 SHALL give rst priority over all other inputs, and an asserted reset during EMIT SHALL abandon the row with no transfer.

Configuration
REQ-029 SHALL use the macro OBSTACLE_STATS_EN.
REQ-030 SHALL, when OBSTACLE_STATS_EN is defined, provide drop_cnt, which increments by 1 per dropped tick (only when run=1) and saturates at 255.
REQ-031 SHALL, when OBSTACLE_STATS_EN is undefined, omit the drop_cnt port and its logic, with all other behaviour identical.

Structure
REQ-032 SHALL place in the shared package obstacle_pkg: the NUM_LANES=3 constant, the spawner state enum, the obstacle_row_t struct {lanes, kind, row_id}, and the CENTRE_OPEN_MASK=3'b101 constant.
REQ-033 SHALL contain no sub-module; the parent instantiates lfsr_4 and wires its q output to rand_in.

Verification
REQ-034 SHALL cover: reset, then a tick with rand_in=4'b1011 at tick+1 -> obs_valid at tick+2, lanes=3'b011, kind=1, row_id=0.
REQ-035 SHALL cover: rand_in=4'b0111 in SAMPLE -> lanes=3'b101, kind=0.
REQ-036 SHALL cover: MIN_GAP=2 with ticks every 4 cycles and obs_ready=1 -> rows emitted on ticks 1, 4 and 7 only.
REQ-037 SHALL cover: obs_ready=0 for 10 cycles with 3 ticks in EMIT -> outputs stable, drop_cnt=3 (OBSTACLE_STATS_EN), then one transfer.
REQ-038 SHALL cover: rand_in=4'b1000 in SAMPLE -> no obs_valid, and the next tick samples immediately (gap not loaded).
REQ-039 SHALL cover: rst asserted mid-EMIT -> obs_valid=0 the next cycle, with row_id and drop_cnt cleared to 0.
